// File: rtl/spike_aer_encoder.sv
// Event FIFO: registered storage, head read from the array, refuses push when full even on a pop.
// Latency: push visible at the head one cycle later; backpressure via full (push refused) and pop only when non-empty.
module spike_aer_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // Storage is reset so the head fields read zero straight out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Scans PE spikes in index order once per timestep, queues {tag, index} events, strobes spike_done on push.
// Latency: N_NEURONS SCAN cycles + 1 DONE cycle, +1 per full-FIFO stall; events drain on valid/ready.
module spike_aer_encoder #(
  parameter int N_NEURONS  = 16,
  parameter int IDX_W      = 4,
  parameter int TS_W       = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 scan_start,
  input  logic [TS_W-1:0]      timestep,
  output logic [N_NEURONS-1:0] spike_done,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [IDX_W-1:0]     evt_idx,
  output logic [TS_W-1:0]      evt_ts,
  output logic                 busy,
  output logic                 scan_done,
  output logic [IDX_W:0]       scan_count
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0]     LAST_PTR = IDX_W'(N_NEURONS - 1);
  localparam logic [N_NEURONS-1:0] ONE_HOT0 = N_NEURONS'(1);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        ptr, ptr_nxt;
  logic [TS_W-1:0]         ts_lat, ts_nxt;
  logic [IDX_W:0]          run_cnt, run_nxt;
  logic [IDX_W:0]          scan_count_nxt;
  logic                    hit;
  logic                    push;
  logic                    full;
  logic                    empty;
  logic [TS_W+IDX_W-1:0]   head;

  assign hit       = spike_in[ptr];
  assign busy      = (state != IDLE);
  assign scan_done = (state == DONE);
  assign evt_valid = ~empty;
  assign evt_ts    = head[TS_W+IDX_W-1:IDX_W];
  assign evt_idx   = head[IDX_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      ts_lat     <= '0;
      run_cnt    <= '0;
      scan_count <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      ts_lat     <= ts_nxt;
      run_cnt    <= run_nxt;
      scan_count <= scan_count_nxt;
    end
  end

  // A hit against a full FIFO neither pushes nor advances, so the PE keeps its spike until the retry lands.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    ts_nxt         = ts_lat;
    run_nxt        = run_cnt;
    scan_count_nxt = scan_count;
    push           = 1'b0;
    spike_done     = '0;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_nxt = SCAN;
          ptr_nxt   = '0;
          ts_nxt    = timestep;
          run_nxt   = '0;
        end
      end
      SCAN: begin
        push = hit & ~full;
        if (push) begin
          spike_done = ONE_HOT0 << ptr;
          run_nxt    = run_cnt + 1'b1;
        end
        if (!hit || !full) begin
          if (ptr == LAST_PTR) state_nxt = DONE;
          else                 ptr_nxt   = ptr + 1'b1;
        end
      end
      DONE: begin
        state_nxt      = IDLE;
        scan_count_nxt = run_cnt;
      end
      default: state_nxt = IDLE;
    endcase
  end

  spike_aer_fifo #(
    .WIDTH (TS_W + IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({ts_lat, ptr}),
    .pop      (evt_valid & evt_ready),
    .head_dat (head),
    .full     (full),
    .empty    (empty)
  );
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder: directed scenarios plus randomized scans against an event-list model.
module tb_spike_aer_encoder;
  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int TS_W  = 8;
  localparam int DEPTH = 8;

  typedef logic [TS_W+IDX_W-1:0] evq_t[$];

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     spike_in;
  logic             scan_start;
  logic [TS_W-1:0]  timestep;
  logic [N-1:0]     spike_done;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic [TS_W-1:0]  evt_ts;
  logic             busy;
  logic             scan_done;
  logic [IDX_W:0]   scan_count;

  int checks = 0;
  int errors = 0;

  logic [TS_W+IDX_W-1:0] obs_q[$];
  int sd_cnt[N];
  int onehot_err = 0;
  int done_cnt = 0;

  always #5 clock = ~clock;

  spike_aer_encoder #(
    .N_NEURONS (N), .IDX_W (IDX_W), .TS_W (TS_W), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock (clock), .reset_n (reset_n), .spike_in (spike_in), .scan_start (scan_start),
    .timestep (timestep), .spike_done (spike_done), .evt_valid (evt_valid), .evt_ready (evt_ready),
    .evt_idx (evt_idx), .evt_ts (evt_ts), .busy (busy), .scan_done (scan_done), .scan_count (scan_count)
  );

  // Passive monitor: records accepted events, clear strobes and scan completions.
  always @(negedge clock) begin
    if (reset_n) begin
      if (evt_valid && evt_ready) obs_q.push_back({evt_ts, evt_idx});
      for (int i = 0; i < N; i++) if (spike_done[i]) sd_cnt[i]++;
      if ($countones(spike_done) > 1) onehot_err++;
      if (scan_done) done_cnt++;
    end
  end

  // Reference: a scan emits one event per set spike bit, lowest index first, tagged with the scan's timestep.
  function automatic evq_t model_events(input logic [N-1:0] sp, input logic [TS_W-1:0] ts);
    evq_t q;
    q = {};
    for (int i = 0; i < N; i++) if (sp[i]) q.push_back({ts, IDX_W'(i)});
    return q;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_scan(input logic [TS_W-1:0] ts);
    scan_start = 1'b1;
    timestep   = ts;
    step();
    scan_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; scan_start = 1'b0; spike_in = '0; timestep = '0; evt_ready = 1'b0;
    #3;
    checks++; if (spike_done !== '0) begin errors++; $display("FAIL reset_spike_done got %h exp 0", spike_done); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got %b exp 0", evt_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done got %b exp 0", scan_done); end
    checks++; if (scan_count !== '0) begin errors++; $display("FAIL reset_scan_count got %0d exp 0", scan_count); end
    checks++; if ({evt_ts, evt_idx} !== '0) begin errors++; $display("FAIL reset_head got %h exp 0", {evt_ts, evt_idx}); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_spike();
    int base, sd_cyc, done_cyc, sd0;
    logic [N-1:0] sd_val;
    evq_t exp_q;
    base = obs_q.size(); sd0 = sd_cnt[4];
    exp_q = model_events(16'h0010, 8'd5);
    evt_ready = 1'b1; spike_in = 16'h0010;
    start_scan(8'd5);
    sd_cyc = -1; done_cyc = -1; sd_val = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (spike_done != '0 && sd_cyc < 0) begin sd_cyc = k; sd_val = spike_done; end
      if (scan_done && done_cyc < 0) done_cyc = k;
    end
    step();
    checks++; if (sd_cyc !== 5) begin errors++; $display("FAIL single_sd_cycle got %0d exp 5", sd_cyc); end
    checks++; if (sd_val !== 16'h0010) begin errors++; $display("FAIL single_sd_value got %h exp 0010", sd_val); end
    checks++; if (sd_cnt[4] - sd0 !== 1) begin errors++; $display("FAIL single_sd_pulses got %0d exp 1", sd_cnt[4] - sd0); end
    checks++; if (done_cyc !== 17) begin errors++; $display("FAIL single_done_cycle got %0d exp 17", done_cyc); end
    checks++; if (scan_count !== 5'd1) begin errors++; $display("FAIL single_scan_count got %0d exp 1", scan_count); end
    checks++; if (obs_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL single_evt_count got %0d exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int j = 0; j < exp_q.size() && base + j < obs_q.size(); j++) begin
      checks++; if (obs_q[base+j] !== exp_q[j]) begin errors++; $display("FAIL single_event got %h exp %h", obs_q[base+j], exp_q[j]); end
    end
  endtask

  task automatic test_empty_scan();
    int base, sd_seen, done_cyc;
    base = obs_q.size(); evt_ready = 1'b1; spike_in = '0;
    start_scan(8'd9);
    sd_seen = 0; done_cyc = -1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      if (spike_done != '0) sd_seen++;
      if (scan_done && done_cyc < 0) done_cyc = k;
    end
    step();
    checks++; if (sd_seen !== 0) begin errors++; $display("FAIL empty_sd_cycles got %0d exp 0", sd_seen); end
    checks++; if (done_cyc !== 17) begin errors++; $display("FAIL empty_done_cycle got %0d exp 17", done_cyc); end
    checks++; if (scan_count !== 5'd0) begin errors++; $display("FAIL empty_scan_count got %0d exp 0", scan_count); end
    checks++; if (obs_q.size() - base !== 0) begin errors++; $display("FAIL empty_evt_count got %0d exp 0", obs_q.size() - base); end
  endtask

  task automatic test_backpressure();
    int base, sd0[N], d0;
    logic [N-1:0] low_vec, all_vec;
    bit fin;
    evq_t exp_q;
    base = obs_q.size(); sd0 = sd_cnt; d0 = done_cnt;
    exp_q = model_events('1, 8'h21);
    evt_ready = 1'b0; spike_in = '1;
    start_scan(8'h21);
    repeat (20) @(negedge clock);
    low_vec = '0;
    for (int i = 0; i < N; i++) if (sd_cnt[i] - sd0[i] == 1) low_vec[i] = 1'b1;
    checks++; if (low_vec !== 16'h00FF) begin errors++; $display("FAIL bp_stall_sd_bits got %h exp 00ff", low_vec); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_stall_busy got %b exp 1", busy); end
    checks++; if (spike_done !== '0) begin errors++; $display("FAIL bp_stall_spike_done got %h exp 0", spike_done); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL bp_stall_done got %0d exp 0", done_cnt - d0); end
    checks++; if ({evt_valid, evt_ts, evt_idx} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL bp_stall_head got %h exp %h", {evt_valid, evt_ts, evt_idx}, {1'b1, exp_q[0]}); end
    @(posedge clock); #1;
    evt_ready = 1'b1;
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clock);
      fin = (obs_q.size() - base == exp_q.size()) && (done_cnt - d0 == 1);
    end
    repeat (3) step();
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL bp_drain_timeout got %0d events exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int j = 0; j < exp_q.size() && base + j < obs_q.size(); j++) begin
      checks++; if (obs_q[base+j] !== exp_q[j]) begin errors++; $display("FAIL bp_event[%0d] got %h exp %h", j, obs_q[base+j], exp_q[j]); end
    end
    all_vec = '0;
    for (int i = 0; i < N; i++) if (sd_cnt[i] - sd0[i] == 1) all_vec[i] = 1'b1;
    checks++; if (all_vec !== 16'hFFFF) begin errors++; $display("FAIL bp_sd_once got %h exp ffff", all_vec); end
    checks++; if (scan_count !== 5'd16) begin errors++; $display("FAIL bp_scan_count got %0d exp 16", scan_count); end
  endtask

  task automatic test_full_push_pop();
    int base;
    bit fin;
    evq_t exp_q;
    base = obs_q.size();
    exp_q = model_events('1, 8'h33);
    evt_ready = 1'b0; spike_in = '1;
    start_scan(8'h33);
    repeat (15) step();
    evt_ready = 1'b1;
    @(negedge clock);
    checks++; if (spike_done !== '0) begin errors++; $display("FAIL fpp_pop_cycle_sd got %h exp 0", spike_done); end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL fpp_pop_cycle_valid got %b exp 1", evt_valid); end
    @(posedge clock); #1;
    evt_ready = 1'b0;
    @(negedge clock);
    checks++; if (spike_done !== 16'h0100) begin errors++; $display("FAIL fpp_retry_sd got %h exp 0100", spike_done); end
    @(negedge clock);
    checks++; if (spike_done !== '0) begin errors++; $display("FAIL fpp_refull_sd got %h exp 0", spike_done); end
    @(posedge clock); #1;
    evt_ready = 1'b1;
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clock);
      fin = (obs_q.size() - base == exp_q.size()) && !busy;
    end
    step();
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL fpp_drain_timeout got %0d events exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int j = 0; j < exp_q.size() && base + j < obs_q.size(); j++) begin
      checks++; if (obs_q[base+j] !== exp_q[j]) begin errors++; $display("FAIL fpp_event[%0d] got %h exp %h", j, obs_q[base+j], exp_q[j]); end
    end
  endtask

  task automatic test_back_to_back();
    int base, d0, done1, done2;
    bit busy_gap, fin;
    evq_t exp_q, q2;
    base = obs_q.size(); d0 = done_cnt;
    exp_q = model_events(16'hA005, 8'd5);
    q2 = model_events(16'h0300, 8'd6);
    foreach (q2[j]) exp_q.push_back(q2[j]);
    evt_ready = 1'b1; spike_in = 16'hA005;
    start_scan(8'd5);
    done1 = -1; busy_gap = 1'b1;
    for (int k = 1; k <= 30 && done1 < 0; k++) begin
      @(negedge clock);
      if (scan_done) done1 = k;
      @(posedge clock); #1;
      scan_start = (k == 3);
      timestep   = (k == 3) ? 8'd9 : 8'd5;
      if (done1 > 0) begin
        spike_in = 16'h0300; timestep = 8'd6; scan_start = 1'b1;
        @(negedge clock);
        busy_gap = busy;
        @(posedge clock); #1;
        scan_start = 1'b0;
      end
    end
    done2 = -1;
    for (int k = 1; k <= 30 && done2 < 0; k++) begin
      @(negedge clock);
      if (scan_done) done2 = k;
    end
    fin = 1'b0;
    for (int c = 0; c < 50 && !fin; c++) begin
      @(negedge clock);
      fin = (obs_q.size() - base == exp_q.size());
    end
    step();
    checks++; if (done1 !== 17) begin errors++; $display("FAIL b2b_first_done got %0d exp 17", done1); end
    checks++; if (busy_gap !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got %b exp 0", busy_gap); end
    checks++; if (done2 !== 17) begin errors++; $display("FAIL b2b_second_done got %0d exp 17", done2); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_pulses got %0d exp 2", done_cnt - d0); end
    checks++; if (scan_count !== 5'd2) begin errors++; $display("FAIL b2b_scan_count got %0d exp 2", scan_count); end
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL b2b_drain_timeout got %0d events exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int j = 0; j < exp_q.size() && base + j < obs_q.size(); j++) begin
      checks++; if (obs_q[base+j] !== exp_q[j]) begin errors++; $display("FAIL b2b_event[%0d] got %h exp %h", j, obs_q[base+j], exp_q[j]); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int base, d0, sd15;
    base = obs_q.size(); d0 = done_cnt; sd15 = sd_cnt[15];
    evt_ready = 1'b0; spike_in = 16'h8001;
    start_scan(8'd7);
    repeat (3) step();
    checks++; if ({evt_valid, evt_ts, evt_idx} !== {1'b1, 8'd7, 4'd0}) begin errors++; $display("FAIL rst_pre_head got %h exp 1070", {evt_valid, evt_ts, evt_idx}); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({spike_done, evt_valid, busy, scan_done} !== '0) begin errors++; $display("FAIL rst_async_ctrl got %h exp 0", {spike_done, evt_valid, busy, scan_done}); end
    checks++; if ({scan_count, evt_ts, evt_idx} !== '0) begin errors++; $display("FAIL rst_async_data got %h exp 0", {scan_count, evt_ts, evt_idx}); end
    @(posedge clock); #1;
    reset_n = 1'b1; evt_ready = 1'b1;
    repeat (20) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_post_busy got %b exp 0", busy); end
    checks++; if (obs_q.size() - base !== 0) begin errors++; $display("FAIL rst_post_events got %0d exp 0", obs_q.size() - base); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rst_post_done got %0d exp 0", done_cnt - d0); end
    checks++; if (sd_cnt[15] - sd15 !== 0) begin errors++; $display("FAIL rst_post_sd15 got %0d exp 0", sd_cnt[15] - sd15); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int base, d0, sd0[N], extra;
      logic [N-1:0] sp, sd_vec;
      logic [TS_W-1:0] ts;
      bit fin;
      evq_t exp_q;
      sp = N'($urandom); ts = TS_W'($urandom);
      base = obs_q.size(); d0 = done_cnt; sd0 = sd_cnt;
      exp_q = model_events(sp, ts);
      spike_in = sp; evt_ready = ($urandom_range(0, 1) == 1);
      start_scan(ts);
      fin = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        step();
        fin = (obs_q.size() - base == exp_q.size()) && (done_cnt - d0 == 1) && !busy;
      end
      evt_ready = 1'b0;
      step();
      sd_vec = '0; extra = 0;
      for (int i = 0; i < N; i++) begin
        if (sd_cnt[i] - sd0[i] == 1) sd_vec[i] = 1'b1;
        if (sd_cnt[i] - sd0[i] > 1) extra++;
      end
      checks++; if (fin !== 1'b1) begin errors++; $display("FAIL rnd%0d_timeout got %0d events exp %0d", it, obs_q.size() - base, exp_q.size()); end
      checks++; if (scan_count !== (IDX_W+1)'($countones(sp))) begin errors++; $display("FAIL rnd%0d_scan_count got %0d exp %0d", it, scan_count, $countones(sp)); end
      checks++; if (sd_vec !== sp || extra !== 0) begin errors++; $display("FAIL rnd%0d_sd_bits got %h (extra %0d) exp %h", it, sd_vec, extra, sp); end
      for (int j = 0; j < exp_q.size() && base + j < obs_q.size(); j++) begin
        checks++; if (obs_q[base+j] !== exp_q[j]) begin errors++; $display("FAIL rnd%0d_event[%0d] got %h exp %h", it, j, obs_q[base+j], exp_q[j]); end
      end
    end
    checks++; if (onehot_err !== 0) begin errors++; $display("FAIL spike_done_onehot got %0d bad cycles exp 0", onehot_err); end
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_empty_scan();
    test_backpressure();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
